// File: rtl/fetch_unit_pkg.sv
// Shared MIPS defines: opcode constants, fetch FSM encoding, reset PC default.
package fetch_unit_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FN_JR      = 6'h08;

    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_REQ  = 2'd1;
    localparam logic [1:0] FETCH_HOLD = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_unit_target.sv
// Redirect target selection for the instruction sitting in decode (combinational).
module fetch_target
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_id,
    input  logic [25:0] instr_index,
    input  logic        instr_valid_id,
    input  logic        stall,
    input  logic        jump_branch,
    input  logic [31:0] branch_offset,
    input  logic        jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_pc,
    output logic        capture,
    output logic [31:0] target
);

    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_id + 32'd4;

    // Register jump beats J-type, which beats a taken branch
    always_comb begin
        capture = 1'b0;
        target  = '0;
        if (instr_valid_id && !stall) begin
            if (jump_reg) begin
                capture = 1'b1;
                target  = word_align(jr_pc);
            end else if (jump_target) begin
                capture = 1'b1;
                target  = {pc_plus4[31:28], instr_index, 2'b00};
            end else if (jump_branch) begin
                capture = 1'b1;
                target  = word_align(pc_plus4 + branch_offset);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: request FSM, one-entry skid register and delayed-slot redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        jump_branch,
    input  logic [31:0] branch_offset,
    input  logic        jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_pc,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic        instr_valid_id
);

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [31:0] skid_instr;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        capture;
    logic [31:0] sel_target;
    logic        issue;
    logic [31:0] next_addr;

    assign imem_req  = (state == FETCH_REQ);
    assign imem_addr = word_align(addr_q);

    fetch_target u_target (
        .pc_id          (pc_id),
        .instr_index    (instr_id[25:0]),
        .instr_valid_id (instr_valid_id),
        .stall          (stall),
        .jump_branch    (jump_branch),
        .branch_offset  (branch_offset),
        .jump_target    (jump_target),
        .jump_reg       (jump_reg),
        .jr_pc          (jr_pc),
        .capture        (capture),
        .target         (sel_target)
    );

    // A new address issues whenever a word moves into decode; a redirect
    // captured on that same edge already steers it (the issued request is
    // the delay slot)
    always_comb begin
        issue     = 1'b0;
        next_addr = word_align(addr_q + 32'd4);
        if (!stall) begin
            issue = ((state == FETCH_REQ) && imem_ack) || (state == FETCH_HOLD);
        end
        if (capture) begin
            next_addr = sel_target;
        end else if (redir_valid) begin
            next_addr = redir_target;
        end
    end

    // Fetch FSM, decode register, skid register and pending redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FETCH_IDLE;
            addr_q         <= RESET_PC;
            pc_id          <= RESET_PC;
            instr_id       <= '0;
            instr_valid_id <= 1'b0;
            skid_instr     <= '0;
            redir_valid    <= 1'b0;
            redir_target   <= '0;
        end else begin
            case (state)
                FETCH_IDLE: state <= FETCH_REQ;
                FETCH_REQ: begin
                    if (imem_ack) begin
                        if (stall) begin
                            skid_instr <= imem_rdata;
                            state      <= FETCH_HOLD;
                        end else begin
                            pc_id          <= imem_addr;
                            instr_id       <= imem_rdata;
                            instr_valid_id <= 1'b1;
                        end
                    end else if (!stall) begin
                        instr_id       <= '0;
                        instr_valid_id <= 1'b0;
                    end
                end
                FETCH_HOLD: begin
                    if (!stall) begin
                        pc_id          <= imem_addr;
                        instr_id       <= skid_instr;
                        instr_valid_id <= 1'b1;
                        state          <= FETCH_REQ;
                    end
                end
                default: state <= FETCH_IDLE;
            endcase

            if (issue) begin
                addr_q <= next_addr;
            end

            if (issue) begin
                redir_valid <= 1'b0;
            end else if (capture) begin
                redir_valid  <= 1'b1;
                redir_target <= sel_target;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: program-order PC model, memory responder, decode monitor.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC    = 32'h0000_0000;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
    localparam int ACK_ALWAYS = 0;
    localparam int ACK_DELAY2 = 1;
    localparam int ACK_RAND   = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        jump_branch = 1'b0;
    logic [31:0] branch_offset = '0;
    logic        jump_target = 1'b0;
    logic        jump_reg = 1'b0;
    logic [31:0] jr_pc = '0;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        instr_valid_id;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] prog[$];
    exp_t        exp_q[$];
    int          fetch_idx = 0;
    int          deliv = 0;
    int          bubble_run = 0;
    int          last_run = 0;
    int          ack_mode = ACK_ALWAYS;
    int          wait_cnt = 0;
    bit          directed_jumps = 1'b0;
    bit          rand_jumps = 1'b0;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .jump_branch    (jump_branch),
        .branch_offset  (branch_offset),
        .jump_target    (jump_target),
        .jump_reg       (jump_reg),
        .jr_pc          (jr_pc),
        .pc_id          (pc_id),
        .instr_id       (instr_id),
        .instr_valid_id (instr_valid_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Instruction memory contents: a fixed hash of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] j_target(input logic [31:0] p);
        logic [31:0] p4;
        logic [31:0] w;
        p4 = p + 32'd4;
        w  = mem_word(p);
        return {p4[31:28], w[25:0], 2'b00};
    endfunction

    function automatic logic [31:0] rand_offset();
        logic [31:0] r;
        if ($urandom_range(0, 9) == 0) r = $urandom;
        else r = 32'($urandom_range(0, 255)) - 32'd128;
        return r << 2;
    endfunction

    task automatic model_clear();
        prog.delete();
        exp_q.delete();
        prog.push_back(RST_PC);
        prog.push_back(RST_PC + 32'd4);
        exp_q.push_back('{RST_PC, mem_word(RST_PC)});
        exp_q.push_back('{RST_PC + 32'd4, mem_word(RST_PC + 32'd4)});
        fetch_idx = 0;
    endtask

    // Drive one cycle of inputs (called at a negedge); decides redirects and memory responses
    task automatic drive_inputs(input bit st);
        int n;
        int unsigned kind;
        logic [31:0] p;
        logic [31:0] tgt;
        stall         = st;
        jump_branch   = 1'b0;
        jump_target   = 1'b0;
        jump_reg      = 1'b0;
        branch_offset = rand_offset();
        jr_pc         = $urandom & WORD_MASK;
        if (instr_valid_id && !st) begin
            n = deliv - 1;
            chk("decision_sync", 32'(prog.size()), 32'(n + 2));
            if (n >= 0 && prog.size() == n + 2) begin
                p    = prog[n];
                kind = 0;
                if (directed_jumps) begin
                    if (p == 32'h10) begin
                        kind = 1; branch_offset = 32'h20;
                    end else if (p == 32'h38) begin
                        kind = 3; jr_pc = 32'h100; branch_offset = 32'h40; jump_branch = 1'b1;
                    end else if (p == 32'h104) begin
                        kind = 2; jump_branch = 1'b1;
                    end
                end else if (rand_jumps && $urandom_range(0, 99) < 35) begin
                    kind = $urandom_range(1, 3);
                    if (kind >= 2) jump_branch = 1'($urandom_range(0, 1));
                    if (kind == 3) jump_target = 1'($urandom_range(0, 1));
                end
                case (kind)
                    1: begin jump_branch = 1'b1; tgt = p + 32'd4 + branch_offset; end
                    2: begin jump_target = 1'b1; tgt = j_target(p); end
                    3: begin jump_reg = 1'b1; tgt = jr_pc; end
                    default: tgt = prog[n + 1] + 32'd4;
                endcase
                prog.push_back(tgt);
                exp_q.push_back('{tgt, mem_word(tgt)});
            end
        end else if (rand_jumps) begin
            jump_branch = 1'($urandom_range(0, 1));
            jump_target = 1'($urandom_range(0, 1));
            jump_reg    = 1'($urandom_range(0, 1));
        end

        case (ack_mode)
            ACK_ALWAYS: imem_ack = 1'b1;
            ACK_DELAY2: begin
                imem_ack = 1'b0;
                if (imem_req) begin
                    if (wait_cnt == 2) begin imem_ack = 1'b1; wait_cnt = 0; end
                    else wait_cnt++;
                end
            end
            default: imem_ack = ($urandom_range(0, 99) < 60);
        endcase
        if (imem_ack && imem_req) begin
            imem_rdata = mem_word(imem_addr);
            if (fetch_idx < prog.size()) chk("fetch_addr", imem_addr, prog[fetch_idx]);
            else chk("fetch_ahead", 32'(fetch_idx), 32'(prog.size()));
            fetch_idx++;
        end else begin
            imem_rdata = 32'hDEAD_BEEF;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        jump_branch = 1'b0; jump_target = 1'b0; jump_reg = 1'b0;
        model_clear();
        wait_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive_inputs(1'b0);
    endtask

    // Monitor: checks decode outputs after every rising edge against the scoreboard
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] exp_instr = '0;
    logic        exp_valid = 1'b0;
    always begin
        logic rst_s;
        logic stall_s;
        exp_t e;
        @(posedge clk);
        rst_s   = rst;
        stall_s = stall;
        #1;
        if (rst_s) begin
            chk("rst_req", 32'(imem_req), 32'd0);
            chk("rst_addr", imem_addr, RST_PC);
            chk("rst_pc", pc_id, RST_PC);
            chk("rst_instr", instr_id, 32'd0);
            chk("rst_valid", 32'(instr_valid_id), 32'd0);
            exp_pc = RST_PC; exp_instr = '0; exp_valid = 1'b0;
            deliv = 0; bubble_run = 0;
        end else if (stall_s) begin
            chk("stall_hold_pc", pc_id, exp_pc);
            chk("stall_hold_instr", instr_id, exp_instr);
            chk("stall_hold_valid", 32'(instr_valid_id), 32'(exp_valid));
        end else if (instr_valid_id) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", pc_id, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("deliver_pc", pc_id, e.pc);
                chk("deliver_instr", instr_id, e.instr);
                exp_pc = e.pc; exp_instr = e.instr; exp_valid = 1'b1;
            end
            deliv++;
            last_run = bubble_run;
            bubble_run = 0;
        end else begin
            chk("bubble_instr", instr_id, 32'd0);
            chk("bubble_pc", pc_id, exp_pc);
            exp_instr = '0; exp_valid = 1'b0;
            bubble_run++;
        end
        if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int d0;

        // Boot with ack tied high and directed redirects
        ack_mode = ACK_ALWAYS;
        directed_jumps = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("boot_req", 32'(imem_req), 32'd1);
            chk("boot_addr", imem_addr, 32'(i * 4));
            drive_inputs(1'b0);
        end
        repeat (24) begin @(negedge clk); drive_inputs(1'b0); end
        directed_jumps = 1'b0;

        // Three-cycle stall while an ack lands
        repeat (2) begin @(negedge clk); drive_inputs(1'b0); end
        @(negedge clk); drive_inputs(1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_req", 32'(imem_req), 32'd0);
            drive_inputs(k < 2);
        end
        @(negedge clk);
        chk("resume_req", 32'(imem_req), 32'd1);
        drive_inputs(1'b0);
        repeat (6) begin @(negedge clk); drive_inputs(1'b0); end

        // Ack delayed two cycles
        ack_mode = ACK_DELAY2;
        wait_cnt = 0;
        repeat (15) begin @(negedge clk); drive_inputs(1'b0); end
        chk("bubbles_per_fetch", 32'(last_run), 32'd2);

        // Reset while fetch to 0x40 is outstanding
        ack_mode = ACK_ALWAYS;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h40) found = 1'b1;
            else drive_inputs(1'b0);
        end
        chk("reach_0x40", 32'(found), 32'd1);
        rst = 1'b1; imem_ack = 1'b0; stall = 1'b0;
        jump_branch = 1'b0; jump_target = 1'b0; jump_reg = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rst_abandon_req", 32'(imem_req), 32'd0);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0040;
        @(negedge clk);
        chk("late_ack_valid", 32'(instr_valid_id), 32'd0);
        chk("late_ack_instr", instr_id, 32'd0);
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_addr", imem_addr, RST_PC);
        drive_inputs(1'b0);
        repeat (10) begin @(negedge clk); drive_inputs(1'b0); end

        // Randomized traffic
        ack_mode = ACK_RAND;
        rand_jumps = 1'b1;
        d0 = deliv;
        repeat (1500) begin
            @(negedge clk);
            drive_inputs($urandom_range(0, 99) < 25);
        end
        chk("progress", 32'(deliv - d0 >= 150), 32'd1);

        // Drain and confirm no lost or duplicated expectations
        ack_mode = ACK_ALWAYS;
        rand_jumps = 1'b0;
        repeat (10) begin @(negedge clk); drive_inputs(1'b0); end
        chk("sb_depth", 32'(exp_q.size()), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
